// File: rtl/ctrl_input_debouncer_if.sv
// rtl/ctrl_input_debouncer_if.sv - switch input / debounced control word bundle
interface ctrl_input_debouncer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] ctrl_raw;
    logic [WIDTH-1:0] ctrl_out;
    logic             ctrl_changed;
    logic             busy;

    modport master (
        output ctrl_raw,
        input  ctrl_out,
        input  ctrl_changed,
        input  busy
    );

    modport slave (
        input  ctrl_raw,
        output ctrl_out,
        output ctrl_changed,
        output busy
    );
endinterface

// File: rtl/ctrl_input_debouncer.sv
// rtl/ctrl_input_debouncer.sv - 2-flop sync plus per-bit debounce of raw switch inputs
// Define CTRL_DEBOUNCE_BYPASS_EN to drop the counters and pass the synchronized bits straight through.
module ctrl_input_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ctrl_input_debouncer_if.slave bus
);
    logic [WIDTH-1:0] ff1;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] out_q;
    logic             changed_q;

    // ctrl_raw goes straight into ff1: nothing may sit in front of the first sync flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= '0;
            s   <= '0;
        end else begin
            ff1 <= bus.ctrl_raw;
            s   <= ff1;
        end
    end

`ifdef CTRL_DEBOUNCE_BYPASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            out_q     <= s;
            changed_q <= (s != out_q);
        end
    end

    assign bus.busy = 1'b0;
`else
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] commit;
    logic             busy_c;

    always_comb begin
        commit = '0;
        busy_c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            commit[i] = (s[i] != out_q[i]) && (cnt[i] == CNT_LAST);
            busy_c    = busy_c | (|cnt[i]);
        end
    end

    // A bit that returns to its committed value before the count completes starts over from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            out_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == out_q[i]) begin
                    cnt[i] <= '0;
                end else if (commit[i]) begin
                    cnt[i]   <= '0;
                    out_q[i] <= s[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            changed_q <= |commit;
        end
    end

    assign bus.busy = busy_c;
`endif

    assign bus.ctrl_out     = out_q;
    assign bus.ctrl_changed = changed_q;
endmodule

// File: tb/tb_ctrl_input_debouncer.sv
// tb/tb_ctrl_input_debouncer.sv - randomized and directed bench for ctrl_input_debouncer
module tb_ctrl_input_debouncer;
    localparam int W      = 4;
    localparam int STABLE = 4;
`ifdef CTRL_DEBOUNCE_BYPASS_EN
    localparam int LAT = 3;
`else
    localparam int LAT = STABLE + 2;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    ctrl_input_debouncer_if #(.WIDTH(W)) dif ();

    ctrl_input_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a bit commits once its synchronized value has differed from the
    // committed value for STABLE consecutive edges; the sync path is a 2-edge delay.
    logic [W-1:0] m_ff1, m_s, m_out, nx_out;
    logic         m_changed, m_busy;
    int           m_run [W];
    int           nx_run [W];

    always_comb begin
        nx_out = m_out;
        m_busy = 1'b0;
        for (int i = 0; i < W; i++) begin
            nx_run[i] = 0;
`ifdef CTRL_DEBOUNCE_BYPASS_EN
            nx_out[i] = m_s[i];
`else
            if (m_s[i] != m_out[i]) begin
                if (m_run[i] + 1 >= STABLE) nx_out[i] = m_s[i];
                else nx_run[i] = m_run[i] + 1;
            end
            if (m_run[i] != 0) m_busy = 1'b1;
`endif
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ff1     <= '0;
            m_s       <= '0;
            m_out     <= '0;
            m_changed <= 1'b0;
            for (int i = 0; i < W; i++) m_run[i] <= 0;
        end else begin
            m_ff1     <= dif.ctrl_raw;
            m_s       <= m_ff1;
            m_out     <= nx_out;
            m_changed <= (nx_out != m_out);
            for (int i = 0; i < W; i++) m_run[i] <= nx_run[i];
        end
    end

    function automatic logic [W+1:0] obs();
        return {dif.ctrl_out, dif.ctrl_changed, dif.busy};
    endfunction

    function automatic logic [W+1:0] expv();
        return {m_out, m_changed, m_busy};
    endfunction

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first, pulses;
        rst_n = 1'b0;
        dif.ctrl_raw = 4'b1010;
        for (int e = 0; e < 4; e++) begin
            edge_wait();
            n_checks++;
            if (obs() !== '0) $display("FAIL reset_hold out/chg/busy=%b required 000000", obs());
            else n_pass++;
        end
        rst_n = 1'b1;
        first = 0;
        pulses = 0;
        for (int e = 1; e <= LAT + 3; e++) begin
            edge_wait();
            n_checks++;
            if (obs() !== expv()) $display("FAIL reset_release_model edge %0d got %b required %b", e, obs(), expv());
            else n_pass++;
            if (dif.ctrl_out == 4'b1010 && first == 0) first = e;
            if (dif.ctrl_changed) pulses++;
        end
        n_checks++;
        if (first !== LAT) $display("FAIL reset_release_latency got %0d required %0d", first, LAT);
        else n_pass++;
        n_checks++;
        if (pulses !== 1) $display("FAIL reset_release_pulses got %0d required 1", pulses);
        else n_pass++;
    endtask

    task automatic test_single_change();
        int first, pulses, busy_seen;
        dif.ctrl_raw = 4'b0000;
        for (int e = 0; e < LAT + 4; e++) edge_wait();
        n_checks++;
        if (obs() !== 6'b0) $display("FAIL single_idle got %b required 000000", obs());
        else n_pass++;
        dif.ctrl_raw = 4'b0110;
        first = 0;
        pulses = 0;
        busy_seen = 0;
        for (int e = 1; e <= LAT + 4; e++) begin
            edge_wait();
            n_checks++;
            if (obs() !== expv()) $display("FAIL single_model edge %0d got %b required %b", e, obs(), expv());
            else n_pass++;
            if (dif.ctrl_out == 4'b0110 && first == 0) first = e;
            if (dif.ctrl_changed) pulses++;
            if (dif.busy) busy_seen++;
        end
        n_checks++;
        if (first !== LAT) $display("FAIL single_latency got %0d required %0d", first, LAT);
        else n_pass++;
        n_checks++;
        if (pulses !== 1) $display("FAIL single_pulses got %0d required 1", pulses);
        else n_pass++;
`ifndef CTRL_DEBOUNCE_BYPASS_EN
        n_checks++;
        if (busy_seen !== STABLE - 1) $display("FAIL single_busy_cycles got %0d required %0d", busy_seen, STABLE - 1);
        else n_pass++;
`endif
        n_checks++;
        if (dif.busy !== 1'b0) $display("FAIL single_busy_end got %b required 0", dif.busy);
        else n_pass++;
    endtask

`ifndef CTRL_DEBOUNCE_BYPASS_EN
    task automatic test_bounce();
        int pulses, busy_seen, out_moves;
        logic [W-1:0] raw;
        pulses = 0;
        busy_seen = 0;
        out_moves = 0;
        raw = 4'b0110;
        for (int c = 0; c < 12 + 10; c++) begin
            if (c < 12) raw[0] = ((c / 2) % 2 == 0);
            else raw[0] = 1'b0;
            dif.ctrl_raw = raw;
            edge_wait();
            n_checks++;
            if (obs() !== expv()) $display("FAIL bounce_model cycle %0d got %b required %b", c, obs(), expv());
            else n_pass++;
            if (dif.ctrl_out !== 4'b0110) out_moves++;
            if (dif.ctrl_changed) pulses++;
            if (dif.busy) busy_seen++;
        end
        n_checks++;
        if (out_moves !== 0) $display("FAIL bounce_out_moved got %0d cycles required 0", out_moves);
        else n_pass++;
        n_checks++;
        if (pulses !== 0) $display("FAIL bounce_pulses got %0d required 0", pulses);
        else n_pass++;
        n_checks++;
        if (busy_seen == 0 || dif.busy !== 1'b0) $display("FAIL bounce_busy seen %0d final %b required >0 and 0", busy_seen, dif.busy);
        else n_pass++;
    endtask
`endif

    task automatic watch(input logic [W-1:0] target, output int first, output int pulses);
        first = 0;
        pulses = 0;
        for (int e = 1; e <= LAT + 3; e++) begin
            edge_wait();
            if (dif.ctrl_out == target && first == 0) first = e;
            if (dif.ctrl_changed) pulses++;
        end
    endtask

    task automatic test_all_bits();
        int first, pulses;
        dif.ctrl_raw = 4'b0000;
        for (int e = 0; e < LAT + 4; e++) edge_wait();
        dif.ctrl_raw = 4'b1111;
        watch(4'b1111, first, pulses);
        n_checks++;
        if (first !== LAT || pulses !== 1) $display("FAIL all_rise edge %0d pulses %0d required %0d and 1", first, pulses, LAT);
        else n_pass++;
        dif.ctrl_raw = 4'b0111;
        watch(4'b0111, first, pulses);
        n_checks++;
        if (first !== LAT || pulses !== 1) $display("FAIL bit3_fall edge %0d pulses %0d required %0d and 1", first, pulses, LAT);
        else n_pass++;
        n_checks++;
        if (obs() !== expv()) $display("FAIL all_bits_model got %b required %b", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int first, pulses;
        dif.ctrl_raw = 4'b1111;
        for (int e = 0; e < 4; e++) edge_wait();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 6'b0) $display("FAIL async_reset_immediate got %b required 000000", obs());
        else n_pass++;
        edge_wait();
        n_checks++;
        if (obs() !== 6'b0) $display("FAIL async_reset_held got %b required 000000", obs());
        else n_pass++;
        rst_n = 1'b1;
        watch(4'b1111, first, pulses);
        n_checks++;
        if (first !== LAT || pulses !== 1) $display("FAIL async_reset_recommit edge %0d pulses %0d required %0d and 1", first, pulses, LAT);
        else n_pass++;
    endtask

`ifdef CTRL_DEBOUNCE_BYPASS_EN
    task automatic test_bypass();
        int first, pulses, busy_seen;
        dif.ctrl_raw = 4'b0000;
        for (int e = 0; e < 6; e++) edge_wait();
        dif.ctrl_raw = 4'b1001;
        first = 0;
        pulses = 0;
        busy_seen = 0;
        for (int e = 1; e <= 6; e++) begin
            edge_wait();
            if (dif.ctrl_out == 4'b1001 && first == 0) first = e;
            if (dif.ctrl_changed) pulses++;
            if (dif.busy) busy_seen++;
        end
        n_checks++;
        if (first !== 3 || pulses !== 1 || busy_seen !== 0) $display("FAIL bypass edge %0d pulses %0d busy %0d required 3 1 0", first, pulses, busy_seen);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        int hold;
        for (int c = 0; c < 400; c++) begin
            if (hold <= 0) begin
                dif.ctrl_raw = W'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            edge_wait();
            n_checks++;
            if (obs() !== expv()) $display("FAIL random_model cycle %0d got %b required %b", c, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        dif.ctrl_raw = '0;
        test_reset();
        test_single_change();
`ifndef CTRL_DEBOUNCE_BYPASS_EN
        test_bounce();
`endif
        test_all_bits();
        test_async_reset();
`ifdef CTRL_DEBOUNCE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
